hps_cnn_ctrl: RTL

FPGA-side sequencer between the HPS PIO exports and the CNN accelerator core. It takes image words that HPS software strobes in over the data/valid PIO pair and writes them into the accelerator input buffer. It then starts the convolution on the HPS request, waits for completion (with timeout), latches the logits and holds them until software acknowledges retrieval. It drives the 8-bit state PIO and the run-cycle debug counter PIO.

---
 rtl/hps_cnn_pkg.sv | 13 +
 rtl/hps_cnn_ctrl_rise_detect.sv | 17 +
 rtl/hps_cnn_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/hps_cnn_pkg.sv
// hps_cnn_pkg: shared state encodings and logit defaults for the HPS/CNN sequencer
package hps_cnn_pkg;
    localparam int NUM_LOGITS_DEF = 10;
    localparam int LOGIT_W_DEF    = 32;

    typedef enum logic [7:0] {
        ST_LOAD  = 8'h01,
        ST_READY = 8'h02,
        ST_RUN   = 8'h03,
        ST_DONE  = 8'h04,
        ST_ERROR = 8'hEE
    } state_e;
endpackage

// File: rtl/hps_cnn_ctrl_rise_detect.sv
// rise_detect: single-bit rising-edge detector; history resets high so a level held through reset is not an edge
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic prev_q, prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk) begin
        prev_q <= reset ? 1'b1 : prev_d;
    end

    assign rise = d & ~prev_q;
endmodule

// File: rtl/hps_cnn_ctrl.sv
// hps_cnn_ctrl: sequences HPS image upload, CNN start/completion with timeout, and logit hand-back
module hps_cnn_ctrl
    import hps_cnn_pkg::*;
#(
    parameter int NUM_WORDS      = 784,
    parameter int ADDR_W         = 10,
    parameter int NUM_LOGITS     = NUM_LOGITS_DEF,
    parameter int LOGIT_W        = LOGIT_W_DEF,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   hps_data,
    input  logic                          hps_data_valid,
    input  logic                          hps_start_conv,
    input  logic                          hps_logits_retrieved,
    output logic [7:0]                    hps_state,
    output logic                          buf_we,
    output logic [ADDR_W-1:0]             buf_addr,
    output logic [31:0]                   buf_wdata,
    output logic                          cnn_start,
    input  logic                          cnn_done,
    input  logic [NUM_LOGITS*LOGIT_W-1:0] cnn_logits,
    output logic [NUM_LOGITS*LOGIT_W-1:0] logits,
    output logic [31:0]                   run_cycles
);
    logic data_rise, start_rise, ack_rise;

    rise_detect u_data  (.clk(clk), .reset(reset), .d(hps_data_valid),       .rise(data_rise));
    rise_detect u_start (.clk(clk), .reset(reset), .d(hps_start_conv),       .rise(start_rise));
    rise_detect u_ack   (.clk(clk), .reset(reset), .d(hps_logits_retrieved), .rise(ack_rise));

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic                buf_we_q, buf_we_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [31:0]         buf_wdata_q, buf_wdata_d;
    logic                cnn_start_q, cnn_start_d;
    logic [31:0]         run_cycles_q, run_cycles_d;
    logic [LOGIT_W-1:0]  logits_q [NUM_LOGITS];
    logic [LOGIT_W-1:0]  logits_d [NUM_LOGITS];
    logic                last_word, tmo_hit, latch;

    assign last_word = word_cnt_q == ADDR_W'(NUM_WORDS - 1);
    // run_cycles doubles as the timeout counter since it is cleared on entry to RUN
    assign tmo_hit   = run_cycles_q == 32'(TIMEOUT_CYCLES - 1);
    assign latch     = state_q == ST_RUN && cnn_done;

    always_ff @(posedge clk) begin
        state_q <= reset ? ST_LOAD : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:            if (data_rise && last_word) state_d = ST_READY;
            ST_READY:           if (start_rise) state_d = ST_RUN;
            ST_RUN:             state_d = cnn_done ? ST_DONE : tmo_hit ? ST_ERROR : ST_RUN;
            ST_DONE, ST_ERROR:  if (ack_rise) state_d = ST_LOAD;
            default:            state_d = ST_LOAD;
        endcase
    end

    always_comb hps_state = state_q;

    always_comb begin
        buf_we_d     = state_q == ST_LOAD && data_rise;
        buf_addr_d   = buf_we_d ? word_cnt_q : buf_addr_q;
        buf_wdata_d  = buf_we_d ? hps_data : buf_wdata_q;
        word_cnt_d   = !buf_we_d ? word_cnt_q : last_word ? '0 : word_cnt_q + 1'b1;
        cnn_start_d  = state_q == ST_READY && start_rise;
        run_cycles_d = cnn_start_d ? '0 :
                       (state_q == ST_RUN && !(&run_cycles_q)) ? run_cycles_q + 32'd1 : run_cycles_q;
        for (int k = 0; k < NUM_LOGITS; k++)
            logits_d[k] = latch ? cnn_logits[k*LOGIT_W +: LOGIT_W] : logits_q[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q   <= '0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_wdata_q  <= '0;
            cnn_start_q  <= 1'b0;
            run_cycles_q <= '0;
            logits_q     <= '{default: '0};
        end else begin
            word_cnt_q   <= word_cnt_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_wdata_q  <= buf_wdata_d;
            cnn_start_q  <= cnn_start_d;
            run_cycles_q <= run_cycles_d;
            logits_q     <= logits_d;
        end
    end

    assign buf_we     = buf_we_q;
    assign buf_addr   = buf_addr_q;
    assign buf_wdata  = buf_wdata_q;
    assign cnn_start  = cnn_start_q;
    assign run_cycles = run_cycles_q;

    for (genvar i = 0; i < NUM_LOGITS; i++) begin : g_logit
        assign logits[i*LOGIT_W +: LOGIT_W] = logits_q[i];
    end
endmodule
